// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction-to-state encoder: entry states, condition codes, field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_enc_pkg;

    // Control-unit entry states (zero-extended to the encoder's state width)
    localparam int ST_SKIP   = 1;
    localparam int ST_DP_REG = 10;
    localparam int ST_DP_IMM = 11;
    localparam int ST_DP_SHI = 12;
    localparam int ST_CMP    = 13;
    localparam int ST_MOV    = 14;
    localparam int ST_DP_SHR = 15;
    localparam int ST_LDR    = 20;
    localparam int ST_LDR_R  = 21;
    localparam int ST_LDRB   = 22;
    localparam int ST_STR    = 25;
    localparam int ST_STR_R  = 26;
    localparam int ST_STRB   = 27;
    localparam int ST_B      = 30;
    localparam int ST_BL     = 31;
    localparam int ST_UNDEF  = 63;

    // ARM condition field encodings
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    // Instruction field positions
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int CLS_MSB   = 27;
    localparam int CLS_LSB   = 25;
    localparam int OP_MSB    = 24;
    localparam int OP_LSB    = 21;
    localparam int BIT_P     = 24;
    localparam int BIT_B     = 22;
    localparam int BIT_W     = 21;
    localparam int BIT_L     = 20;
    localparam int SHF_MSB   = 11;
    localparam int SHF_LSB   = 4;
    localparam int BIT_SHREG = 4;
    localparam int BIT_MUL   = 7;

    // Flag positions inside the NZCV nibble
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/instr_state_encoder_cond_eval.sv
// Evaluates an ARM condition field against NZCV flags; with COND_EN=0 only AL passes.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module cond_eval
    import instr_enc_pkg::*;
#(
    parameter int COND_EN = 1
) (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;
    assign n = flags_i[FLG_N];
    assign z = flags_i[FLG_Z];
    assign c = flags_i[FLG_C];
    assign v = flags_i[FLG_V];

    // Standard ARM condition table; NV never passes here (the decoder traps it first)
    always_comb begin
        pass_o = 1'b0;
        if (COND_EN != 0) begin
            case (cond_i)
                COND_EQ: pass_o = z;
                COND_NE: pass_o = !z;
                COND_CS: pass_o = c;
                COND_CC: pass_o = !c;
                COND_MI: pass_o = n;
                COND_PL: pass_o = !n;
                COND_VS: pass_o = v;
                COND_VC: pass_o = !v;
                COND_HI: pass_o = c && !z;
                COND_LS: pass_o = !c || z;
                COND_GE: pass_o = (n == v);
                COND_LT: pass_o = (n != v);
                COND_GT: pass_o = !z && (n == v);
                COND_LE: pass_o = z || (n != v);
                COND_AL: pass_o = 1'b1;
                default: pass_o = 1'b0;
            endcase
        end else begin
            pass_o = (cond_i == COND_AL);
        end
    end

endmodule

// File: rtl/instr_state_encoder.sv
// Maps an ARM-subset instruction plus NZCV flags to the control unit's entry state; counts undefined encodings.
// Latency: 1 cycle from accept to out_valid; one accept per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while out_valid && !out_ready.
module instr_state_encoder
    import instr_enc_pkg::*;
#(
    parameter int STATE_W     = 6,
    parameter int COND_EN     = 1,
    parameter int CNT_W       = 8,
    parameter int SKIP_STATE  = ST_SKIP,
    parameter int UNDEF_STATE = ST_UNDEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [3:0]         in_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               out_undef,
    output logic [CNT_W-1:0]   undef_cnt
);

    logic               out_valid_q;
    logic [STATE_W-1:0] out_state_q;
    logic               out_undef_q;
    logic [CNT_W-1:0]   undef_cnt_q, undef_cnt_d;

    logic               accept;
    logic               cond_pass;
    logic [STATE_W-1:0] dec_state;
    logic               dec_undef;

    logic [3:0] cond;
    logic [2:0] cls;
    logic [3:0] op;
    logic [7:0] shf;
    logic       b_p, b_b, b_w, b_l, b_shreg, b_mul;

    assign cond    = in_instr[COND_MSB:COND_LSB];
    assign cls     = in_instr[CLS_MSB:CLS_LSB];
    assign op      = in_instr[OP_MSB:OP_LSB];
    assign shf     = in_instr[SHF_MSB:SHF_LSB];
    assign b_p     = in_instr[BIT_P];
    assign b_b     = in_instr[BIT_B];
    assign b_w     = in_instr[BIT_W];
    assign b_l     = in_instr[BIT_L];
    assign b_shreg = in_instr[BIT_SHREG];
    assign b_mul   = in_instr[BIT_MUL];

    // Register numbers and offsets do not affect the entry state
    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_instr[19:12], in_instr[3:0]};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    cond_eval #(
        .COND_EN (COND_EN)
    ) u_cond_eval (
        .cond_i  (cond),
        .flags_i (in_flags),
        .pass_o  (cond_pass)
    );

    // Priority decode: NV trap, then condition, then instruction class
    always_comb begin
        dec_state = STATE_W'(UNDEF_STATE);
        dec_undef = 1'b1;
        if (cond == COND_NV) begin
            dec_state = STATE_W'(UNDEF_STATE);
        end else if (!cond_pass) begin
            dec_state = STATE_W'(SKIP_STATE);
            dec_undef = 1'b0;
        end else if (cls == 3'b000 && b_shreg && b_mul) begin
            dec_state = STATE_W'(UNDEF_STATE);
        end else if (cls == 3'b000 || cls == 3'b001) begin
            dec_undef = 1'b0;
            if (op[3:2] == 2'b10)                 dec_state = STATE_W'(ST_CMP);
            else if (op == 4'b1101 || op == 4'b1111) dec_state = STATE_W'(ST_MOV);
            else if (cls == 3'b001)               dec_state = STATE_W'(ST_DP_IMM);
            else if (shf == 8'd0)                 dec_state = STATE_W'(ST_DP_REG);
            else if (!b_shreg)                    dec_state = STATE_W'(ST_DP_SHI);
            else                                  dec_state = STATE_W'(ST_DP_SHR);
        end else if ((cls == 3'b010 || cls == 3'b011) && b_p && !b_w) begin
            // cls[0] is the register-offset bit
            dec_undef = 1'b0;
            if (b_l) begin
                if (b_b)         dec_state = STATE_W'(ST_LDRB);
                else if (!cls[0]) dec_state = STATE_W'(ST_LDR);
                else             dec_state = STATE_W'(ST_LDR_R);
            end else begin
                if (b_b)         dec_state = STATE_W'(ST_STRB);
                else if (!cls[0]) dec_state = STATE_W'(ST_STR);
                else             dec_state = STATE_W'(ST_STR_R);
            end
        end else if (cls == 3'b101) begin
            dec_undef = 1'b0;
            dec_state = b_p ? STATE_W'(ST_BL) : STATE_W'(ST_B);
        end
    end

    // Saturating undefined-encoding counter next value
    always_comb begin
        undef_cnt_d = undef_cnt_q;
        if (accept && dec_undef && (undef_cnt_q != {CNT_W{1'b1}})) begin
            undef_cnt_d = undef_cnt_q + 1'b1;
        end
    end

    // Output pipeline register with hold under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_undef_q <= 1'b0;
            undef_cnt_q <= '0;
        end else begin
            undef_cnt_q <= undef_cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_state_q <= dec_state;
                out_undef_q <= dec_undef;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_undef = out_undef_q;
    assign undef_cnt = undef_cnt_q;

endmodule

// File: tb/tb_instr_state_encoder.sv
// Directed bench for instr_state_encoder: default instance plus a COND_EN=0 / CNT_W=2 instance on shared inputs.
// Latency: checks each state one cycle after accept.
// Backpressure: exercises out_ready stalls and reset during an in-flight output.
module tb_instr_state_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [3:0]  in_flags;
    logic        out_ready;

    logic        in_ready, out_valid, out_undef;
    logic [5:0]  out_state;
    logic [7:0]  undef_cnt;

    logic        in_ready2, out_valid2, out_undef2;
    logic [5:0]  out_state2;
    logic [1:0]  undef_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_state_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_undef (out_undef),
        .undef_cnt (undef_cnt)
    );

    instr_state_encoder #(
        .COND_EN (0),
        .CNT_W   (2)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_instr  (in_instr),
        .in_flags  (in_flags),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_state (out_state2),
        .out_undef (out_undef2),
        .undef_cnt (undef_cnt2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_flags = 4'h0; in_instr = 32'h0;
        step; step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        // reset with a concurrent valid instruction: reset must win
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'hE2800005; in_flags = 4'h0; out_ready = 1'b1;
        step; step;
        checks++;
        if (out_valid !== 1'b0 || out_state !== 6'd0 || out_undef !== 1'b0 || undef_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b state=%0d undef=%b cnt=%0d want 0/0/0/0", out_valid, out_state, out_undef, undef_cnt);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid2 !== 1'b0 || undef_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b valid2=%b cnt2=%0d want 1/0/0", in_ready, out_valid2, undef_cnt2);
        end
    endtask

    task automatic test_data_proc;
        logic [31:0] w [6] = '{32'hE0810002, 32'hE2800005, 32'hE3500000, 32'hE3A00001, 32'hE0810102, 32'hE0810312};
        logic [5:0]  e [6] = '{6'd10, 6'd11, 6'd13, 6'd14, 6'd12, 6'd15};
        do_reset;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = w[i];
            step;
            checks++;
            if (out_valid !== 1'b1 || out_state !== e[i] || out_undef !== 1'b0) begin
                errors++;
                $display("FAIL dp[%0d] %h: valid=%b state=%0d undef=%b want 1/%0d/0", i, w[i], out_valid, out_state, out_undef, e[i]);
            end
        end
        in_valid = 1'b0;
        step;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dp_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_mem_branch;
        logic [31:0] w [6] = '{32'hE5910004, 32'hE7910002, 32'hE5D10004, 32'hE5810004, 32'hEA000000, 32'hEB000000};
        logic [5:0]  e [6] = '{6'd20, 6'd21, 6'd22, 6'd25, 6'd30, 6'd31};
        in_valid = 1'b1; in_flags = 4'h0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = w[i];
            step;
            checks++;
            if (out_valid !== 1'b1 || out_state !== e[i] || out_undef !== 1'b0) begin
                errors++;
                $display("FAIL mem[%0d] %h: valid=%b state=%0d undef=%b want 1/%0d/0", i, w[i], out_valid, out_state, out_undef, e[i]);
            end
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_conditions;
        logic [31:0] w  [4] = '{32'h0A000000, 32'h0A000000, 32'hBA000000, 32'hEA000000};
        logic [3:0]  f  [4] = '{4'b0000, 4'b0100, 4'b1000, 4'b0000};
        logic [5:0]  e  [4] = '{6'd1, 6'd30, 6'd30, 6'd30};
        logic [5:0]  e2 [4] = '{6'd1, 6'd1, 6'd1, 6'd30};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = w[i]; in_flags = f[i];
            step;
            checks++;
            if (out_state !== e[i] || out_undef !== 1'b0 || out_state2 !== e2[i] || out_undef2 !== 1'b0) begin
                errors++;
                $display("FAIL cond[%0d] %h flags=%b: state=%0d state_nc=%0d want %0d/%0d", i, w[i], f[i], out_state, out_state2, e[i], e2[i]);
            end
        end
        in_valid = 1'b0; in_flags = 4'h0;
        step;
    endtask

    task automatic test_undef;
        logic [31:0] w [4] = '{32'hE0000091, 32'hFA000000, 32'h00000091, 32'hE4910004};
        logic [5:0]  e [4] = '{6'd63, 6'd63, 6'd1, 6'd63};
        logic        u [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0]  c [4] = '{8'd1, 8'd2, 8'd2, 8'd3};
        do_reset;
        in_valid = 1'b1; in_flags = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_instr = w[i];
            step;
            checks++;
            if (out_state !== e[i] || out_undef !== u[i] || undef_cnt !== c[i]) begin
                errors++;
                $display("FAIL undef[%0d] %h: state=%0d undef=%b cnt=%0d want %0d/%b/%0d", i, w[i], out_state, out_undef, undef_cnt, e[i], u[i], c[i]);
            end
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_saturate;
        do_reset;
        in_valid = 1'b1; in_instr = 32'hE0000091;
        for (int i = 0; i < 5; i++) step;
        in_valid = 1'b0;
        step;
        checks++;
        if (undef_cnt2 !== 2'd3 || undef_cnt !== 8'd5) begin
            errors++;
            $display("FAIL saturate: cnt_w2=%0d cnt_w8=%0d want 3/5", undef_cnt2, undef_cnt);
        end
        // counter persists while idle
        step; step;
        checks++;
        if (undef_cnt2 !== 2'd3 || undef_cnt !== 8'd5) begin
            errors++;
            $display("FAIL saturate_hold: cnt_w2=%0d cnt_w8=%0d want 3/5", undef_cnt2, undef_cnt);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        in_valid = 1'b1; in_instr = 32'hE2800005; out_ready = 1'b1;
        step;
        out_ready = 1'b0; in_instr = 32'hE0810002;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: in_ready=%b want 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (out_valid !== 1'b1 || out_state !== 6'd11 || out_undef !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b state=%0d in_ready=%b want 1/11/0", i, out_valid, out_state, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
        end
        step;
        checks++;
        if (out_valid !== 1'b1 || out_state !== 6'd10) begin
            errors++;
            $display("FAIL bp_release_take: valid=%b state=%0d want 1/10", out_valid, out_state);
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_reset_mid;
        do_reset;
        in_valid = 1'b1; in_instr = 32'hE0000091; out_ready = 1'b1;
        step; step;
        checks++;
        if (out_valid !== 1'b1 || undef_cnt !== 8'd2) begin
            errors++;
            $display("FAIL rmid_pre: valid=%b cnt=%0d want 1/2", out_valid, undef_cnt);
        end
        reset = 1'b1; in_instr = 32'hE2800005;
        step;
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_state !== 6'd0 || out_undef !== 1'b0 || undef_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rmid_post: valid=%b state=%0d undef=%b cnt=%0d want 0/0/0/0", out_valid, out_state, out_undef, undef_cnt);
        end
        step;
        checks++;
        if (out_valid !== 1'b0 || out_state !== 6'd0) begin
            errors++;
            $display("FAIL rmid_no_capture: valid=%b state=%0d want 0/0", out_valid, out_state);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_flags = 4'h0; out_ready = 1'b1;
        test_reset;
        test_data_proc;
        test_mem_branch;
        test_conditions;
        test_undef;
        test_saturate;
        test_backpressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
